// File: rtl/core_decode.sv
// rtl/core_decode.sv - TOY decode/operand-fetch stage with register file, scoreboard and hazard stall
module core_decode #(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inst_valid_i,
  input  logic [W-1:0] inst_i,
  output logic         inst_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [2:0]   alu_op_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [3:0]   op_o,
  output logic [3:0]   d_o,
  output logic [7:0]   addr_o,
  input  logic         wb_en_i,
  input  logic [3:0]   wb_addr_i,
  input  logic [W-1:0] wb_data_i,
  input  logic         flush_i,
  output logic         halted_o
);

  logic [W-1:0]    r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_out_valid;
  logic            r_halted;
  logic [2:0]      r_alu_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [3:0]      r_op;
  logic [3:0]      r_d;
  logic [7:0]      r_addr;

  logic [3:0]      w_op;
  logic [3:0]      w_d;
  logic [3:0]      w_s;
  logic [3:0]      w_t;
  logic [7:0]      w_addr;
  logic [W-1:0]    w_rd;
  logic [W-1:0]    w_rs;
  logic [W-1:0]    w_rt;
  logic            w_use_d;
  logic            w_use_s;
  logic            w_use_t;
  logic            w_writer;
  logic            w_held_writer;
  logic            w_hazard;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;
  logic            w_flush_hit;
  logic [2:0]      w_alu_op;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [NREG-1:0] w_busy_nxt;

  function automatic logic f_writer(input logic [3:0] op, input logic [3:0] d);
    f_writer = (d != 4'd0) &&
               (((op >= 4'd1) && (op <= 4'd8)) || (op == 4'hA) || (op == 4'hF));
  endfunction

  assign w_op   = inst_i[15:12];
  assign w_d    = inst_i[11:8];
  assign w_s    = inst_i[7:4];
  assign w_t    = inst_i[3:0];
  assign w_addr = inst_i[7:0];

  // Same-cycle writeback forwarding; R0 always reads zero.
  assign w_rd = (w_d == 4'd0) ? '0 : (wb_en_i && wb_addr_i == w_d) ? wb_data_i : r_regs[w_d];
  assign w_rs = (w_s == 4'd0) ? '0 : (wb_en_i && wb_addr_i == w_s) ? wb_data_i : r_regs[w_s];
  assign w_rt = (w_t == 4'd0) ? '0 : (wb_en_i && wb_addr_i == w_t) ? wb_data_i : r_regs[w_t];

  assign w_use_s  = (w_op >= 4'd1) && (w_op <= 4'd6);
  assign w_use_t  = w_use_s || (w_op == 4'hA) || (w_op == 4'hB);
  assign w_use_d  = (w_op == 4'h9) || (w_op == 4'hB) || (w_op == 4'hC) ||
                    (w_op == 4'hD) || (w_op == 4'hE);
  assign w_writer = f_writer(w_op, w_d);
  assign w_held_writer = f_writer(r_op, r_d);

  // WAW stalls even if the busy bit is being cleared this cycle.
  assign w_hazard = (w_use_s && r_busy[w_s] && !(wb_en_i && wb_addr_i == w_s)) ||
                    (w_use_t && r_busy[w_t] && !(wb_en_i && wb_addr_i == w_t)) ||
                    (w_use_d && r_busy[w_d] && !(wb_en_i && wb_addr_i == w_d)) ||
                    (w_writer && r_busy[w_d]);

  assign w_ready     = !r_halted && !flush_i && !w_hazard && (!r_out_valid || out_ready_i);
  assign w_accept    = inst_valid_i && w_ready;
  assign w_issue     = w_accept && (w_op != 4'd0);
  assign w_flush_hit = flush_i && r_out_valid;

  always_comb begin
    w_alu_op = 3'd7;
    w_a      = '0;
    w_b      = '0;
    case (w_op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        w_alu_op = w_op[2:0] - 3'd1;
        w_a      = w_rs;
        w_b      = w_rt;
      end
      4'h7, 4'h8, 4'hF: w_b = {{(W-8){1'b0}}, w_addr};
      4'h9: begin
        w_a = w_rd;
        w_b = {{(W-8){1'b0}}, w_addr};
      end
      4'hA: w_b = w_rt;
      4'hB: begin
        w_a = w_rd;
        w_b = w_rt;
      end
      4'hC, 4'hD, 4'hE: begin
        w_alu_op = 3'd6;
        w_a      = w_rd;
      end
      default: w_alu_op = 3'd7;
    endcase
  end

  // Issue set is applied last so it wins over a writeback clear on the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en_i)
      w_busy_nxt[wb_addr_i] = 1'b0;
    if (w_flush_hit && w_held_writer)
      w_busy_nxt[r_d] = 1'b0;
    if (w_issue && w_writer)
      w_busy_nxt[w_d] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_alu_op    <= 3'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 4'd0;
      r_d         <= 4'd0;
      r_addr      <= 8'd0;
    end else begin
      if (wb_en_i && wb_addr_i != 4'd0)
        r_regs[wb_addr_i] <= wb_data_i;
      r_busy <= w_busy_nxt;
      if (w_accept && w_op == 4'd0)
        r_halted <= 1'b1;
      if (w_flush_hit) begin
        r_out_valid <= 1'b0;
      end else if (w_issue) begin
        r_out_valid <= 1'b1;
        r_alu_op    <= w_alu_op;
        r_a         <= w_a;
        r_b         <= w_b;
        r_op        <= w_op;
        r_d         <= w_d;
        r_addr      <= w_addr;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign inst_ready_o = w_ready;
  assign out_valid_o  = r_out_valid;
  assign halted_o     = r_halted;
  assign alu_op_o     = r_alu_op;
  assign a_o          = r_a;
  assign b_o          = r_b;
  assign op_o         = r_op;
  assign d_o          = r_d;
  assign addr_o       = r_addr;

endmodule

// File: tb/tb_core_decode.sv
// tb/tb_core_decode.sv - directed plus randomized check of core_decode against a table-driven model
module tb_core_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [15:0] a_val;
  logic [15:0] b_val;
  logic [3:0]  op_val;
  logic [3:0]  d_val;
  logic [7:0]  addr_val;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        halted;

  always #5 clk = ~clk;

  core_decode #(.NREG(16), .W(16)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .inst_valid_i(inst_valid), .inst_i(inst), .inst_ready_o(inst_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_op_o(alu_op), .a_o(a_val), .b_o(b_val), .op_o(op_val), .d_o(d_val), .addr_o(addr_val),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush), .halted_o(halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-opcode tables: alu code, A source (0 zero, 1 R[s], 2 R[d]), B source (0 zero, 1 R[t], 2 addr), writer.
  int alu_tab [16] = '{0, 0, 1, 2, 3, 4, 5, 7, 7, 7, 7, 7, 6, 6, 6, 7};
  int a_tab   [16] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 2, 0, 2, 2, 2, 2, 0};
  int b_tab   [16] = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 1, 1, 0, 0, 0, 2};
  int wr_tab  [16] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1};

  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          m_ov, m_halt;
  logic [2:0]  m_alu;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_op, m_d;
  logic [7:0]  m_addr;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_busy[i] = 1'b0;
    end
    m_ov = 0; m_halt = 0; m_alu = 0; m_a = 0; m_b = 0; m_op = 0; m_d = 0; m_addr = 0;
  endtask

  function automatic logic [15:0] m_rd(input int idx);
    if (idx == 0) return 16'h0;
    if (wb_en && int'(wb_addr) == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_writes(input int op, input int d);
    return wr_tab[op] == 1 && d != 0;
  endfunction

  function automatic bit m_stall(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    int d  = int'(ins[11:8]);
    int srcs[$];
    if (a_tab[op] == 1) srcs.push_back(int'(ins[7:4]));
    if (a_tab[op] == 2) srcs.push_back(d);
    if (b_tab[op] == 1) srcs.push_back(int'(ins[3:0]));
    foreach (srcs[k])
      if (m_busy[srcs[k]] && !(wb_en && int'(wb_addr) == srcs[k])) return 1'b1;
    return m_writes(op, d) && m_busy[d];
  endfunction

  function automatic bit m_ready();
    return !m_halt && !flush && !m_stall(inst) && (!m_ov || out_ready);
  endfunction

  task automatic m_step();
    bit acc = inst_valid && m_ready();
    int op  = int'(inst[15:12]);
    int d   = int'(inst[11:8]);
    logic [15:0] na = 16'h0, nb = 16'h0;
    if (a_tab[op] == 1) na = m_rd(int'(inst[7:4]));
    if (a_tab[op] == 2) na = m_rd(d);
    if (b_tab[op] == 1) nb = m_rd(int'(inst[3:0]));
    if (b_tab[op] == 2) nb = {8'h00, inst[7:0]};
    if (wb_en) m_busy[wb_addr] = 1'b0;
    if (flush && m_ov && m_writes(int'(m_op), int'(m_d))) m_busy[m_d] = 1'b0;
    if (acc && op != 0 && m_writes(op, d)) m_busy[d] = 1'b1;
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (acc && op == 0) m_halt = 1'b1;
    if (flush && m_ov) m_ov = 1'b0;
    else if (acc && op != 0) begin
      m_ov = 1'b1; m_alu = 3'(alu_tab[op]); m_a = na; m_b = nb;
      m_op = inst[15:12]; m_d = inst[11:8]; m_addr = inst[7:0];
    end else if (out_ready) m_ov = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("halted", halted, m_halt);
    check("alu_op", alu_op, m_alu);
    check("a", a_val, m_a);
    check("b", b_val, m_b);
    check("op", op_val, m_op);
    check("d", d_val, m_d);
    check("addr", addr_val, m_addr);
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic fl);
    inst_valid = v; inst = ins; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
  endtask

  task automatic tick();
    #1;
    check("inst_ready", inst_ready, m_ready());
    @(posedge clk);
    if (rst_n) m_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_busy();
    for (int r = 1; r < 16; r++) begin
      drive(0, 16'h0, 1, 1, 4'(r), 16'($urandom), 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0, 1, 0, 4'h0, 16'h0, 0);
    m_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: subtract with operands from writeback
    drive(0, 16'h0, 1, 1, 4'h1, 16'h0005, 0); tick();
    drive(0, 16'h0, 1, 1, 4'h2, 16'h0003, 0); tick();
    drive(1, 16'h2312, 1, 0, 4'h0, 16'h0, 0); tick();
    check("p1_valid", out_valid, 1); check("p1_alu", alu_op, 1);
    check("p1_a", a_val, 16'h0005); check("p1_b", b_val, 16'h0003); check("p1_d", d_val, 3);
    drive(1, 16'h1433, 1, 0, 4'h0, 16'h0, 0); #1;
    check("p1_busy3_stall", inst_ready, 0);
    drive(0, 16'h0, 1, 1, 4'h3, 16'h0002, 0); tick();

    // 2: RAW stall released by forwarded writeback
    drive(1, 16'h1312, 1, 0, 4'h0, 16'h0, 0); tick();
    drive(1, 16'h1433, 1, 0, 4'h0, 16'h0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("p2_stalled", inst_ready, 0);
    drive(1, 16'h1433, 1, 1, 4'h3, 16'h0008, 0); #1;
    check("p2_ready_on_wb", inst_ready, 1);
    tick();
    check("p2_a_fwd", a_val, 16'h0008); check("p2_b_fwd", b_val, 16'h0008);

    // 3: load-immediate to R0
    clear_busy();
    drive(1, 16'h70AB, 1, 0, 4'h0, 16'h0, 0); tick();
    check("p3_alu", alu_op, 7); check("p3_a", a_val, 0); check("p3_b", b_val, 16'h00AB); check("p3_d", d_val, 0);

    // 4: backpressure holds the bundle
    drive(1, 16'h1556, 1, 0, 4'h0, 16'h0, 0); tick();
    drive(1, 16'h7077, 0, 0, 4'h0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p4_hold_op", op_val, 4'h1);
    end
    drive(1, 16'h7077, 1, 0, 4'h0, 16'h0, 0); #1;
    check("p4_ready_release", inst_ready, 1);
    tick();
    check("p4_b", b_val, 16'h0077);

    // 5: flush drops the held bundle and its busy bit
    clear_busy();
    drive(1, 16'h1512, 0, 0, 4'h0, 16'h0, 0); tick();
    drive(1, 16'h1655, 0, 0, 4'h0, 16'h0, 1); tick();
    check("p5_flushed", out_valid, 0);
    drive(1, 16'h1655, 1, 0, 4'h0, 16'h0, 0); #1;
    check("p5_no_stall", inst_ready, 1);
    tick();

    // randomized traffic against the model
    clear_busy();
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] ins;
      logic        we;
      logic [3:0]  wa;
      int          busy_list[$];
      ins = 16'($urandom);
      if (ins[15:12] == 4'h0) ins[15:12] = 4'h1;
      if ($urandom_range(0, 1) == 1) begin
        ins[11:8] = 4'($urandom_range(0, 5));
        ins[7:4]  = 4'($urandom_range(0, 5));
        ins[3:0]  = 4'($urandom_range(0, 5));
      end
      for (int r = 1; r < 16; r++) if (m_busy[r]) busy_list.push_back(r);
      we = ($urandom_range(0, 9) < 4);
      if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
        wa = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wa = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) != 0, we, wa, 16'($urandom),
            $urandom_range(0, 19) == 0);
      tick();
    end

    // 6: halt is sticky; async reset clears everything
    clear_busy();
    drive(1, 16'h1712, 1, 0, 4'h0, 16'h0, 0); tick();
    drive(0, 16'h0, 1, 0, 4'h0, 16'h0, 0); tick();
    drive(1, 16'h0000, 1, 0, 4'h0, 16'h0, 0); tick();
    check("p6_halted", halted, 1);
    drive(1, 16'h7011, 1, 0, 4'h0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p6_no_accept", inst_ready, 0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0); check("rst_halted", halted, 0);
    check("rst_alu", alu_op, 0); check("rst_a", a_val, 0); check("rst_b", b_val, 0);
    check("rst_op", op_val, 0); check("rst_d", d_val, 0); check("rst_addr", addr_val, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h1877, 1, 0, 4'h0, 16'h0, 0); #1;
    check("rst_busy_cleared", inst_ready, 1);
    tick();
    check("rst_r7_zero", a_val, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
